// File: rtl/mxu_feeder_pkg.sv
// mxu_feeder_pkg
// Shared types for the MXU feeder: the per-vector info word, the two FSM
// state encodings and the default width of the tile/row count fields.
package mxu_feeder_pkg;

  localparam int DEFAULT_CNT_W = 16;

  // Bit order matches the MXU side-band: {last_tile, new_tile_k, valid}.
  typedef struct packed {
    logic last_tile;
    logic new_tile_k;
    logic valid;
  } feeder_info_t;

  typedef enum logic [1:0] {A_IDLE, A_WAIT, A_STREAM} a_state_t;
  typedef enum logic [1:0] {B_IDLE, B_LOAD, B_HELD}   b_state_t;

  // Info word for a vector that is actually being emitted.
  function automatic feeder_info_t mk_info(input logic is_last, input logic is_new);
    mk_info = '{last_tile: is_last, new_tile_k: is_new, valid: 1'b1};
  endfunction

endpackage

// File: rtl/mxu_feeder_row_ctr.sv
// mxu_feeder_row_ctr
// Row counter that wraps to 0 after i_limit increments.
//   clk, rst  : clock, asynchronous active-high reset
//   i_clr     : synchronous clear (new command)
//   i_inc     : count one accepted row
//   i_limit   : rows per tile
//   o_count   : current row index within the tile
//   o_tc      : terminal count (current row is the last of the tile)
module mxu_feeder_row_ctr
  import mxu_feeder_pkg::*;
#(
  parameter int W = DEFAULT_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_inc,
  input  logic [W-1:0] i_limit,
  output logic [W-1:0] o_count,
  output logic         o_tc
);

  logic [W-1:0] r_count;

  assign o_count = r_count;
  assign o_tc    = (r_count == i_limit - W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= o_tc ? '0 : r_count + W'(1);
    end
  end

endmodule

// File: rtl/mxu_feeder.sv
// mxu_feeder
// Converts valid/ready streams of weight rows (b) and feature rows (a) into
// the push-only, info-tagged a/b vector streams of the MXU. Weight loading of
// tile t+1 into the MXU b shadow overlaps a-streaming of tile t.
//   clk, resetn              : clock, asynchronous active-high reset
//   start, n_k_tiles, n_rows : command pulse and its parameters
//   busy, done               : command in progress / completion pulse
//   a_src_*, b_src_*         : source streams (valid/ready)
//   a, ainfo, b, binfo       : registered vectors + {last_tile,new_tile_k,valid}
module mxu_feeder
  import mxu_feeder_pkg::*;
#(
  parameter int SZI     = 8,
  parameter int SZJ     = 8,
  parameter int A_WIDTH = 8,
  parameter int B_WIDTH = 8,
  parameter int CNT_W   = DEFAULT_CNT_W
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   start,
  input  logic [CNT_W-1:0]       n_k_tiles,
  input  logic [CNT_W-1:0]       n_rows,
  output logic                   busy,
  output logic                   done,
  input  logic [SZJ*A_WIDTH-1:0] a_src_data,
  input  logic                   a_src_valid,
  output logic                   a_src_ready,
  input  logic [SZJ*B_WIDTH-1:0] b_src_data,
  input  logic                   b_src_valid,
  output logic                   b_src_ready,
  output logic [SZJ*A_WIDTH-1:0] a,
  output logic [2:0]             ainfo,
  output logic [SZJ*B_WIDTH-1:0] b,
  output logic [2:0]             binfo
);

  a_state_t r_a_state, w_a_state_next;
  b_state_t r_b_state, w_b_state_next;

  logic [CNT_W-1:0] r_n_k, r_n_rows, r_a_tile, r_b_tile;
  logic             r_busy, r_done, r_b_loaded;
  logic [SZJ*A_WIDTH-1:0] r_a;
  logic [SZJ*B_WIDTH-1:0] r_b;
  feeder_info_t     r_ainfo, r_binfo;

  logic [CNT_W-1:0] w_a_row, w_b_row;
  logic w_a_tc, w_b_tc;
  logic w_start_ok, w_start_zero, w_launch;
  logic w_b_fire, w_b_last_fire, w_b_avail, w_b_release, w_b_last_tile;
  logic w_a_ready, w_a_fire, w_a_new, w_a_last_row_fire, w_a_last_tile, w_a_done_fire;

  assign w_start_ok   = start && !r_busy;
  assign w_start_zero = w_start_ok && ((n_k_tiles == '0) || (n_rows == '0));
  assign w_launch     = w_start_ok && !w_start_zero;

  assign w_a_last_tile = (r_a_tile == r_n_k - CNT_W'(1));
  assign w_b_last_tile = (r_b_tile == r_n_k - CNT_W'(1));

  assign w_b_fire      = b_src_valid && (r_b_state == B_LOAD);
  assign w_b_last_fire = w_b_fire && w_b_tc;
  // A tile may open in the same cycle its final b row is accepted: the last b
  // row and the swapping a row reach the MXU on the same output cycle, which
  // keeps the a stream gap-free between tiles when n_rows >= SZI.
  assign w_b_avail     = r_b_loaded || w_b_last_fire;

  assign w_a_ready         = (r_a_state == A_STREAM) || ((r_a_state == A_WAIT) && w_b_avail);
  assign w_a_fire          = a_src_valid && w_a_ready;
  assign w_a_new           = w_a_fire && (w_a_row == '0);
  assign w_a_last_row_fire = w_a_fire && w_a_tc;
  assign w_a_done_fire     = w_a_last_row_fire && w_a_last_tile;

  // The a swap frees the shadow held for the tile it opens.
  assign w_b_release = w_a_new && ((r_b_state == B_HELD) || w_b_last_fire);

  mxu_feeder_row_ctr #(.W(CNT_W)) u_a_row (
    .clk(clk), .rst(resetn), .i_clr(w_launch), .i_inc(w_a_fire),
    .i_limit(r_n_rows), .o_count(w_a_row), .o_tc(w_a_tc)
  );

  mxu_feeder_row_ctr #(.W(CNT_W)) u_b_row (
    .clk(clk), .rst(resetn), .i_clr(w_launch), .i_inc(w_b_fire),
    .i_limit(CNT_W'(SZI)), .o_count(w_b_row), .o_tc(w_b_tc)
  );

  always_comb begin
    w_a_state_next = r_a_state;
    case (r_a_state)
      A_IDLE:  if (w_launch) w_a_state_next = A_WAIT;
      A_WAIT, A_STREAM: begin
        if (w_a_fire) begin
          if (!w_a_tc)           w_a_state_next = A_STREAM;
          else if (w_a_last_tile) w_a_state_next = A_IDLE;
          else                   w_a_state_next = A_WAIT;
        end
      end
      default: w_a_state_next = A_IDLE;
    endcase
  end

  always_comb begin
    w_b_state_next = r_b_state;
    case (r_b_state)
      B_IDLE: if (w_launch) w_b_state_next = B_LOAD;
      B_LOAD: begin
        if (w_b_last_fire) begin
          if (!w_b_release)       w_b_state_next = B_HELD;
          else if (w_b_last_tile) w_b_state_next = B_IDLE;
          else                    w_b_state_next = B_LOAD;
        end
      end
      B_HELD: begin
        if (w_b_release) w_b_state_next = w_b_last_tile ? B_IDLE : B_LOAD;
      end
      default: w_b_state_next = B_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      r_a_state  <= A_IDLE;
      r_b_state  <= B_IDLE;
      r_n_k      <= '0;
      r_n_rows   <= '0;
      r_a_tile   <= '0;
      r_b_tile   <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_b_loaded <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_ainfo    <= '0;
      r_binfo    <= '0;
    end else begin
      r_a_state <= w_a_state_next;
      r_b_state <= w_b_state_next;

      if (w_start_ok) begin
        r_n_k    <= n_k_tiles;
        r_n_rows <= n_rows;
      end

      if (w_launch)           r_busy <= 1'b1;
      else if (w_a_done_fire) r_busy <= 1'b0;
      r_done <= w_start_zero || w_a_done_fire;

      // Consuming the shadow wins over a load completing in the same cycle.
      if (w_launch || w_a_new) r_b_loaded <= 1'b0;
      else if (w_b_last_fire)  r_b_loaded <= 1'b1;

      // Tile counters saturate on the final tile.
      if (w_launch)                                r_a_tile <= '0;
      else if (w_a_last_row_fire && !w_a_last_tile) r_a_tile <= r_a_tile + CNT_W'(1);
      if (w_launch)                                r_b_tile <= '0;
      else if (w_b_release && !w_b_last_tile)       r_b_tile <= r_b_tile + CNT_W'(1);

      // Push-only outputs: no handshake means an all-zero bubble.
      r_a     <= w_a_fire ? a_src_data : '0;
      r_ainfo <= w_a_fire ? mk_info(w_a_last_tile, w_a_row == '0) : '0;
      r_b     <= w_b_fire ? b_src_data : '0;
      r_binfo <= w_b_fire ? mk_info(w_b_last_tile, w_b_row == '0) : '0;
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign a_src_ready = w_a_ready;
  assign b_src_ready = (r_b_state == B_LOAD);
  assign a           = r_a;
  assign ainfo       = r_ainfo;
  assign b           = r_b;
  assign binfo       = r_binfo;

endmodule
